traffic_monitor: RTL

Passive protocol checker sitting on the lamp outputs of the two-road traffic light controller. It samples the six lamp lines and the shared 1 Hz `tick` every clock, and decodes the current phase. It checks lamp legality, phase order and phase durations, reporting violations as one-cycle pulses plus a sticky flag. It is used in simulation benches and as an on-chip safety monitor, and never drives the controller.

---
 rtl/traffic_monitor.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/traffic_monitor.sv
// Passive lamp-protocol checker for the two-road traffic light controller.
// Latency: a violation sampled at edge k pulses for one cycle after edge k.
// Backpressure: none; observe-only, never stalls or drives the controller.
module traffic_monitor #(
    parameter int G_TICKS = 5,
    parameter int Y_TICKS = 2,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ns_g,
    input  logic             ns_y,
    input  logic             ns_r,
    input  logic             ew_g,
    input  logic             ew_y,
    input  logic             ew_r,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_dur,
    output logic             err_any,
    output logic [7:0]       cycles
);

    typedef enum logic {UNSYNC, TRACK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] G_EXP   = CNT_W'(G_TICKS);
    localparam logic [CNT_W-1:0] Y_EXP   = CNT_W'(Y_TICKS);

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             partial_q, partial_d;
    logic             ovr_q, ovr_d;
    logic             ill_q, ill_d;
    logic             seq_q, seq_d;
    logic             dur_q, dur_d;
    logic             any_q, any_d;
    logic [7:0]       cycles_q, cycles_d;

    logic [5:0]       lamps;
    logic             samp_vld;
    logic [1:0]       samp_phase;
    logic [1:0]       succ_phase;
    logic [CNT_W-1:0] exp_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_start;

    assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};

    // Only the four exact two-lamp patterns are legal; anything else is illegal.
    always_comb begin
        samp_vld   = 1'b1;
        samp_phase = 2'd0;
        case (lamps)
            6'b100001: samp_phase = 2'd0;
            6'b010001: samp_phase = 2'd1;
            6'b001100: samp_phase = 2'd2;
            6'b001010: samp_phase = 2'd3;
            default:   samp_vld   = 1'b0;
        endcase
    end

    assign succ_phase = phase_q + 2'd1;
    assign exp_cnt    = phase_q[0] ? Y_EXP : G_EXP;
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign cnt_start  = tick ? CNT_ONE : '0;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        partial_d = partial_q;
        ovr_d     = ovr_q;
        ill_d     = 1'b0;
        seq_d     = 1'b0;
        dur_d     = 1'b0;
        cycles_d  = cycles_q;

        case (state_q)
            TRACK: begin
                if (!samp_vld) begin
                    ill_d   = 1'b1;
                    state_d = UNSYNC;
                end else if (samp_phase == phase_q) begin
                    if (tick) begin
                        cnt_d = cnt_inc;
                        // Overrun fires once, on the tick that passes the expected count.
                        if (cnt_q == exp_cnt && !ovr_q) begin
                            dur_d = 1'b1;
                            ovr_d = 1'b1;
                        end
                    end
                end else if (samp_phase == succ_phase) begin
                    if (!partial_q && !ovr_q && cnt_q != exp_cnt)
                        dur_d = 1'b1;
                    if (phase_q == 2'd3)
                        cycles_d = cycles_q + 8'd1;
                    phase_d   = samp_phase;
                    cnt_d     = cnt_start;
                    partial_d = 1'b0;
                    ovr_d     = 1'b0;
                end else begin
                    seq_d     = 1'b1;
                    phase_d   = samp_phase;
                    cnt_d     = cnt_start;
                    partial_d = 1'b1;
                    ovr_d     = 1'b0;
                end
            end
            UNSYNC: begin
                if (samp_vld) begin
                    state_d   = TRACK;
                    phase_d   = samp_phase;
                    cnt_d     = cnt_start;
                    partial_d = 1'b1;
                    ovr_d     = 1'b0;
                end
            end
        endcase

        any_d = any_q | ill_d | seq_d | dur_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TRACK;
            phase_q   <= 2'd0;
            cnt_q     <= '0;
            partial_q <= 1'b0;
            ovr_q     <= 1'b0;
            ill_q     <= 1'b0;
            seq_q     <= 1'b0;
            dur_q     <= 1'b0;
            any_q     <= 1'b0;
            cycles_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
            ovr_q     <= ovr_d;
            ill_q     <= ill_d;
            seq_q     <= seq_d;
            dur_q     <= dur_d;
            any_q     <= any_d;
            cycles_q  <= cycles_d;
        end
    end

    assign phase       = phase_q;
    assign locked      = (state_q == TRACK);
    assign err_illegal = ill_q;
    assign err_seq     = seq_q;
    assign err_dur     = dur_q;
    assign err_any     = any_q;
    assign cycles      = cycles_q;

endmodule
